// File: rtl/dadder_dp_out_sink_pkg.sv
// Shared types and default sizing for the dadder dp_out result sink.
package dadder_dp_out_sink_pkg;

  localparam int DP_DATA_WIDTH_DEF = 32;
  localparam int DP_FIFO_DEPTH_DEF = 4;
  localparam int DP_CNT_WIDTH_DEF  = 16;

  // One buffered dadder result at the default sum width; packed as {sum, ovf}.
  typedef struct packed {
    logic [DP_DATA_WIDTH_DEF-1:0] sum;
    logic                         ovf;
  } dp_res_t;

endpackage

// File: rtl/dadder_dp_out_sink_fifo.sv
// Result buffer for the dp_out sink: storage, wrapping pointers and occupancy.
// No fall-through: a written entry is only visible once the occupancy register
// has been updated, i.e. the cycle after the push.
module dadder_dp_out_sink_fifo
  import dadder_dp_out_sink_pkg::*;
#(
  parameter int WIDTH = DP_DATA_WIDTH_DEF + 1,
  parameter int DEPTH = DP_FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Next pointer/occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; stale contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/dadder_dp_out_sink.sv
// dadder dp_out sink: buffers results, counts them, and flags producers that
// drop or alter a result while it is being stalled.
module dadder_dp_out_sink
  import dadder_dp_out_sink_pkg::*;
#(
  parameter int DATA_WIDTH = DP_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = DP_FIFO_DEPTH_DEF,
  parameter int CNT_WIDTH  = DP_CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_sum,
  input  logic                  in_ovf,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_ovf,
  output logic [CNT_WIDTH-1:0]  res_cnt,
  output logic [CNT_WIDTH-1:0]  ovf_cnt,
  input  logic                  cnt_clr,
  output logic                  proto_err,
  input  logic                  err_clr
);

  localparam int EW = DATA_WIDTH + 1;

  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] fifo_rdata;

  logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic                  stall_q, stall_d;
  logic [DATA_WIDTH-1:0] stall_sum_q, stall_sum_d;
  logic                  stall_ovf_q, stall_ovf_d;
  logic                  proto_err_q, proto_err_d;
  logic                  viol;

  // Ready depends only on registered occupancy; reset_n gates it low while in reset.
  assign in_rdy  = reset_n & ~fifo_full;
  assign out_vld = ~fifo_empty;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  dadder_dp_out_sink_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   ({in_ovf, in_sum}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {out_ovf, out_sum} = fifo_rdata;

  // Saturating result/overflow counters; clear beats a same-cycle increment.
  always_comb begin
    res_cnt_d = res_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clr) begin
      res_cnt_d = '0;
      ovf_cnt_d = '0;
    end else if (push) begin
      if (res_cnt_q != '1)          res_cnt_d = res_cnt_q + CNT_WIDTH'(1);
      if (in_ovf && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
    end
  end

  // A stalled result must be held unchanged next cycle; a new violation beats err_clr.
  always_comb begin
    stall_d     = in_vld & ~in_rdy;
    stall_sum_d = in_sum;
    stall_ovf_d = in_ovf;
    viol        = stall_q & (~in_vld | (in_sum != stall_sum_q) | (in_ovf != stall_ovf_q));
    proto_err_d = viol | (proto_err_q & ~err_clr);
  end

  // Counter, stall-history and error-flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
      stall_q     <= 1'b0;
      stall_sum_q <= '0;
      stall_ovf_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      res_cnt_q   <= res_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      stall_q     <= stall_d;
      stall_sum_q <= stall_sum_d;
      stall_ovf_q <= stall_ovf_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign res_cnt   = res_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dadder_dp_out_sink.sv
// Directed bench for dadder_dp_out_sink with a scoreboard of expected results.
module tb_dadder_dp_out_sink;
  import dadder_dp_out_sink_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_vld, in_rdy, in_ovf;
  logic [31:0] in_sum;
  logic        out_vld, out_rdy, out_ovf;
  logic [31:0] out_sum;
  logic [15:0] res_cnt, ovf_cnt;
  logic        cnt_clr, proto_err, err_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  int pops_mark;
  logic [15:0] exp_res = '0;
  logic [15:0] exp_ovf = '0;
  dp_res_t sb[$];

  dadder_dp_out_sink dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_sum    (in_sum),
    .in_ovf    (in_ovf),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .res_cnt   (res_cnt),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr),
    .proto_err (proto_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes at the falling edge, update the scoreboard/model, then
  // advance past the next rising edge.
  task automatic tick();
    dp_res_t e;
    logic do_push, do_pop;
    @(negedge clk);
    do_push = in_vld && in_rdy;
    do_pop  = out_vld && out_rdy;
    if (do_pop) begin
      n_pops++;
      chk("pop_has_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_sum", 64'(out_sum), 64'(e.sum));
        chk("pop_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
    if (do_push) begin
      e.sum = in_sum;
      e.ovf = in_ovf;
      sb.push_back(e);
    end
    if (cnt_clr) begin
      exp_res = '0;
      exp_ovf = '0;
    end else if (do_push) begin
      if (exp_res != 16'hFFFF) exp_res = exp_res + 16'd1;
      if (in_ovf && exp_ovf != 16'hFFFF) exp_ovf = exp_ovf + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_vld = 1'b0; in_sum = '0; in_ovf = 1'b0;
    out_rdy = 1'b0; cnt_clr = 1'b0; err_clr = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_res_cnt", 64'(res_cnt), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk); #1;

    // Fill four results with downstream stalled, then drain in order
    for (int i = 1; i <= 4; i++) begin
      in_vld = 1'b1; in_sum = 32'(i); in_ovf = (i == 3);
      if (i == 1) chk("no_fallthrough", 64'(out_vld), 64'd0);
      tick();
      if (i == 1) chk("visible_after_push", 64'(out_vld), 64'd1);
    end
    in_vld = 1'b0; in_ovf = 1'b0;
    chk("full_in_rdy", 64'(in_rdy), 64'd0);
    chk("fill_res_cnt", 64'(res_cnt), 64'd4);
    chk("fill_ovf_cnt", 64'(ovf_cnt), 64'd1);
    out_rdy = 1'b1;
    repeat (4) tick();
    chk("drained_out_vld", 64'(out_vld), 64'd0);
    chk("drained_sb", 64'(sb.size()), 64'd0);

    // Full buffer with push and pop offered together
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_sum = 32'h20 + 32'(i); tick();
    end
    in_sum = 32'h55; out_rdy = 1'b1;
    chk("full_pushpop_in_rdy", 64'(in_rdy), 64'd0);
    tick();
    chk("after_pop_in_rdy", 64'(in_rdy), 64'd1);
    chk("no_push_when_full", 64'(sb.size()), 64'd3);
    tick();
    in_vld = 1'b0;
    repeat (4) tick();
    chk("pushpop_drained", 64'(out_vld), 64'd0);
    chk("pushpop_no_err", 64'(proto_err), 64'd0);

    // Continuous stream of 10 with downstream always ready
    pops_mark = n_pops;
    out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_vld = 1'b1; in_sum = 32'h100 + 32'(i); in_ovf = i[0];
      tick();
    end
    chk("stream_pops_during", 64'(n_pops - pops_mark), 64'd9);
    in_vld = 1'b0; in_ovf = 1'b0;
    tick();
    chk("stream_pops_total", 64'(n_pops - pops_mark), 64'd10);
    chk("stream_empty", 64'(out_vld), 64'd0);

    // Protocol violation while stalled
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_sum = 32'h30 + 32'(i); tick();
    end
    in_sum = 32'h10;
    tick();
    chk("stall_held_no_err", 64'(proto_err), 64'd0);
    in_sum = 32'h11;
    tick();
    chk("viol_sets_err", 64'(proto_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_clears", 64'(proto_err), 64'd0);
    err_clr = 1'b1; in_sum = 32'h12;
    tick();
    err_clr = 1'b0;
    chk("set_beats_clr", 64'(proto_err), 64'd1);
    in_vld = 1'b0; out_rdy = 1'b1;
    repeat (5) tick();
    chk("viol_drained", 64'(out_vld), 64'd0);
    chk("err_sticky", 64'(proto_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_final_clear", 64'(proto_err), 64'd0);

    // Counter saturation and clear
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_res", 64'(res_cnt), 64'd0);
    out_rdy = 1'b1; in_vld = 1'b1; in_ovf = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      in_sum = 32'(i);
      tick();
    end
    chk("res_cnt_allones", 64'(res_cnt), 64'hFFFF);
    in_sum = 32'hABCD; in_ovf = 1'b1;
    tick();
    chk("res_cnt_saturated", 64'(res_cnt), 64'hFFFF);
    chk("res_cnt_model", 64'(res_cnt), 64'(exp_res));
    chk("ovf_cnt_model", 64'(ovf_cnt), 64'(exp_ovf));
    cnt_clr = 1'b1; in_sum = 32'hBEEF;
    tick();
    cnt_clr = 1'b0;
    chk("clr_beats_push_res", 64'(res_cnt), 64'd0);
    chk("clr_beats_push_ovf", 64'(ovf_cnt), 64'd0);
    in_vld = 1'b0; in_ovf = 1'b0;
    repeat (2) tick();

    // Reset with two entries buffered
    out_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1; in_sum = 32'h40 + 32'(i); tick();
    end
    in_vld = 1'b0;
    chk("pre_rst_out_vld", 64'(out_vld), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_vld", 64'(out_vld), 64'd0);
    chk("midrst_in_rdy", 64'(in_rdy), 64'd0);
    chk("midrst_out_sum", 64'(out_sum), 64'd0);
    sb.delete();
    exp_res = '0; exp_ovf = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rel_out_vld", 64'(out_vld), 64'd0);
    chk("rel_in_rdy", 64'(in_rdy), 64'd1);
    chk("rel_res_cnt", 64'(res_cnt), 64'd0);
    chk("rel_ovf_cnt", 64'(ovf_cnt), 64'd0);
    pops_mark = n_pops;
    out_rdy = 1'b1;
    repeat (2) tick();
    chk("no_pop_after_rst", 64'(n_pops - pops_mark), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dadder_dp_out_sink.md
DADDER_DP_OUT_SINK -- requirements
Module: dadder_dp_out_sink

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the sum result.
REQ-002 Parameter FIFO_DEPTH, default 4: buffer entries; power of two, >= 2.
REQ-003 Parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 in_vld  in  1  dadder dp_out result valid.
REQ-007 in_rdy  out  1  sink can accept a result.
REQ-008 in_sum  in  DATA_WIDTH  dadder result sum.
REQ-009 in_ovf  in  1  dadder result overflow flag.
REQ-010 out_vld  out  1  buffered result available downstream.
REQ-011 out_rdy  in  1  downstream accepts result.
REQ-012 out_sum  out  DATA_WIDTH  head-of-buffer sum.
REQ-013 out_ovf  out  1  head-of-buffer overflow flag.
REQ-014 res_cnt  out  CNT_WIDTH  accepted-result count.
REQ-015 ovf_cnt  out  CNT_WIDTH  accepted results with in_ovf=1.
REQ-016 cnt_clr  in  1  synchronous clear of both counters.
REQ-017 proto_err  out  1  sticky dp_out protocol-violation flag.
REQ-018 err_clr  in  1  synchronous clear of proto_err.

Function
REQ-019 Push occurs when in_vld && in_rdy; pop occurs when out_vld && out_rdy.
REQ-020 in_rdy = (occupancy < FIFO_DEPTH), derived only from registered occupancy; no combinational path from out_rdy.
REQ-021 out_vld = (occupancy != 0); out_sum/out_ovf present the oldest entry; no fall-through: a pushed entry becomes visible on out_* the cycle after the push.
REQ-022 Push and pop in the same cycle leave occupancy unchanged; order is strictly FIFO.
REQ-023 When full, in_rdy=0 and no push occurs; a pop in that cycle makes in_rdy=1 in the next cycle.
REQ-024 Read/write pointers wrap modulo FIFO_DEPTH without data loss or duplication.
REQ-025 On each push, res_cnt increments by 1 and ovf_cnt increments by 1 if in_ovf=1; both saturate at all-ones.
REQ-026 cnt_clr=1 forces both counters to 0 next cycle and overrides any same-cycle increment.
REQ-027 Protocol check: if in_vld=1 and in_rdy=0 in cycle N, then in cycle N+1 in_vld shall still be 1 with in_sum/in_ovf unchanged; otherwise proto_err sets the next cycle.
REQ-028 proto_err remains set until err_clr; a set condition in the same cycle as err_clr wins (flag stays 1).
REQ-029 Entries pushed during a protocol violation are still buffered normally.

Reset
REQ-030 While reset_n=0: occupancy=0, pointers=0, out_vld=0, in_rdy=0, out_sum=0, out_ovf=0, res_cnt=0, ovf_cnt=0, proto_err=0, stall-history registers cleared.
REQ-031 In the first cycle after reset_n deasserts, in_rdy=1.
REQ-032 Reset asserted mid-transfer discards all buffered entries; no pop completes after reset.

Structure
REQ-033 Package dadder_dp_out_sink_pkg holds the result struct typedef (sum, ovf) and default parameter constants.
REQ-034 Buffer storage and pointers are in sub-module dadder_dp_out_sink_fifo; counters and protocol check live in the top.

Verification
REQ-035 Push 4 results (sums 1..4, ovf on 3) with out_rdy=0 -> in_rdy=0 after 4th push, res_cnt=4, ovf_cnt=1; then out_rdy=1 -> out_sum 1,2,3,4 in order, out_ovf=1 only with 3.
REQ-036 Full buffer with push and pop offered in the same cycle -> no push accepted, pop completes, in_rdy=1 next cycle.
REQ-037 Continuous stream of 10 results with out_rdy=1 -> throughput 1/cycle after the first, pointers wrap twice, output sequence identical.
REQ-038 Stall (buffer full), change in_sum from 0x10 to 0x11 while in_vld=1 -> proto_err=1 next cycle; err_clr -> 0; err_clr coincident with new violation -> stays 1.
REQ-039 Preload res_cnt to all-ones via 65535 pushes -> further push keeps 0xFFFF; cnt_clr coincident with push -> 0.
REQ-040 Assert reset_n=0 with 2 entries buffered -> out_vld=0 immediately; after release out_vld=0, in_rdy=1, counters 0.
